// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: controller state encoding
// and the depth of the small output holding buffer.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry FIFO-ordered holding buffer for {last,data} words between the
// FIFO read port and the output stream.
module stream_buf2
   import fifo_pkg::*;
#(
   parameter int data_width = 8
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  push_last,
   input  logic [data_width-1:0] push_data,
   input  logic                  pop,
   output logic [data_width-1:0] head_data,
   output logic                  head_last,
   output logic [1:0]            occ
);

   logic [data_width:0] mem [BUF_DEPTH];
   logic                wr_ptr;
   logic                rd_ptr;
   logic                push_ok;
   logic                pop_ok;

   // A full buffer can still take a word when the head leaves in the same cycle.
   assign push_ok = push & ((occ != 2'(BUF_DEPTH)) | pop);
   assign pop_ok  = pop & (occ != 2'd0);

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {push_last, push_data};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign {head_last, head_data} = (occ != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: pulls burst_len words through a FIFO read port
// (data one cycle after rd_en) and presents them on a valid/ready stream.
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int data_width = 8,
   parameter int burst_len  = 16,
   parameter int len_width  = 5
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  fifo_empty,
   output logic                  rd_en,
   input  logic [data_width-1:0] rd_data,
   output logic [data_width-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  burst_done
);

   localparam logic [len_width-1:0] BurstLen = len_width'(burst_len);
   localparam logic [len_width-1:0] LastIdx  = len_width'(burst_len - 1);

   state_t               state;
   state_t               state_next;
   logic [len_width-1:0] issued;
   logic [len_width-1:0] captured;
   logic                 inflight;
   logic                 pop;
   logic                 last_tag;
   logic [1:0]           occ;
   logic [2:0]           credit_used;

   assign pop         = m_valid & m_ready;
   assign credit_used = {1'b0, occ} + {2'b00, inflight};
   // Only issue a read when its word is guaranteed a buffer slot on arrival.
   assign rd_en       = (state == RUN) & ~fifo_empty & (issued < BurstLen)
                        & (credit_used < (3'd2 + {2'b00, pop}));
   assign last_tag    = (captured == LastIdx);
   assign m_valid     = (occ != 2'd0);
   assign busy        = (state != IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (rd_en && (issued == LastIdx)) state_next = DRAIN;
         DRAIN:   if (pop && m_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         issued     <= '0;
         captured   <= '0;
         inflight   <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         state      <= state_next;
         inflight   <= rd_en;
         burst_done <= (state == DRAIN) & pop & m_last;
         if ((state == IDLE) && start) begin
            issued   <= '0;
            captured <= '0;
         end else begin
            if (rd_en) begin
               issued <= issued + len_width'(1);
            end
            if (inflight && (captured < BurstLen)) begin
               captured <= captured + len_width'(1);
            end
         end
      end
   end

   stream_buf2 #(
      .data_width(data_width)
   ) u_buf (
      .rd_clk   (rd_clk),
      .rst_n    (rst_n),
      .push     (inflight),
      .push_last(last_tag),
      .push_data(rd_data),
      .pop      (pop),
      .head_data(m_data),
      .head_last(m_last),
      .occ      (occ)
   );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: three instances (burst_len 4, 3, 1)
// each fed by a behavioural FIFO model with registered read data.
module tb_fifo_burst_reader;

   localparam int NumDut = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      start = '0;
   logic [2:0]      mReady = '0;
   logic [2:0]      fifoEmpty;
   logic [2:0]      rdEn;
   logic [2:0]      mValid;
   logic [2:0]      mLast;
   logic [2:0]      busy;
   logic [2:0]      burstDone;
   logic [2:0][7:0] rdData = '0;
   logic [2:0][7:0] mData;

   logic [7:0] fifoQ [NumDut][$];
   logic [8:0] expQ  [NumDut][$];
   int         fifoCnt   [NumDut] = '{0, 0, 0};
   int         startCyc  [NumDut] = '{0, 0, 0};
   int         rdInBurst [NumDut] = '{0, 0, 0};
   int         doneCnt   [NumDut] = '{0, 0, 0};
   bit         checkLat  [NumDut] = '{0, 0, 0};
   bit         lastAccPrev [NumDut] = '{0, 0, 0};
   bit         prevV [NumDut] = '{0, 0, 0};
   bit         prevR [NumDut] = '{0, 0, 0};
   logic [9:0] prevWord [NumDut];
   int         compared = 0;
   int         failed = 0;
   int         cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   genvar gi;
   generate
      for (gi = 0; gi < NumDut; gi++) begin : g_dut
         fifo_burst_reader #(
            .data_width(8),
            .burst_len ((gi == 0) ? 4 : ((gi == 1) ? 3 : 1)),
            .len_width (5)
         ) u_dut (
            .rd_clk    (clk),
            .rst_n     (rst_n),
            .start     (start[gi]),
            .fifo_empty(fifoEmpty[gi]),
            .rd_en     (rdEn[gi]),
            .rd_data   (rdData[gi]),
            .m_data    (mData[gi]),
            .m_valid   (mValid[gi]),
            .m_last    (mLast[gi]),
            .m_ready   (mReady[gi]),
            .busy      (busy[gi]),
            .burst_done(burstDone[gi])
         );
      end
   endgenerate

   function automatic int blOf(input int g);
      return (g == 0) ? 4 : ((g == 1) ? 3 : 1);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         failed++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // FIFO model: registered read data, zero when not reading; the empty flag
   // follows the queue with one cycle of write-side latency.
   always_comb begin
      for (int g = 0; g < NumDut; g++) fifoEmpty[g] = (fifoCnt[g] == 0);
   end

   always @(posedge clk) begin
      for (int g = 0; g < NumDut; g++) begin
         if (rdEn[g]) begin
            checkOutput("rd_while_empty", int'(fifoEmpty[g]), 0);
            if (fifoQ[g].size() > 0) rdData[g] <= fifoQ[g].pop_front();
            else rdData[g] <= 8'hEE;
         end else begin
            rdData[g] <= '0;
         end
         fifoCnt[g] <= fifoQ[g].size();
      end
   end

   // Monitor: pops the scoreboard on every accepted word, checks hold
   // stability, read count per burst and burst_done placement.
   always @(negedge clk) begin
      for (int g = 0; g < NumDut; g++) begin
         if (!rst_n) begin
            rdInBurst[g]   = 0;
            prevV[g]       = 0;
            lastAccPrev[g] = 0;
         end else begin
            if (prevV[g] && !prevR[g])
               checkOutput("hold_stable", int'({mValid[g], mLast[g], mData[g]}), int'(prevWord[g]));
            if (burstDone[g]) begin
               checkOutput("done_after_last", int'(lastAccPrev[g]), 1);
               checkOutput("reads_per_burst", rdInBurst[g], blOf(g));
               if (checkLat[g]) checkOutput("done_latency", cyc - startCyc[g], blOf(g) + 2);
               rdInBurst[g] = 0;
               doneCnt[g]++;
            end
            if (rdEn[g]) begin
               checkOutput("rd_outside_busy", int'(busy[g]), 1);
               rdInBurst[g]++;
            end
            lastAccPrev[g] = 0;
            if (mValid[g] && mReady[g]) begin
               checkOutput("word_expected", int'(expQ[g].size() > 0), 1);
               if (expQ[g].size() > 0)
                  checkOutput("stream_word", int'({mLast[g], mData[g]}), int'(expQ[g].pop_front()));
               lastAccPrev[g] = mLast[g];
            end
            if (start[g] && !busy[g]) startCyc[g] = cyc + 1;
            prevV[g]    = mValid[g];
            prevR[g]    = mReady[g];
            prevWord[g] = {mValid[g], mLast[g], mData[g]};
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int g, input logic [7:0] data, input logic last);
      fifoQ[g].push_back(data);
      expQ[g].push_back({last, data});
   endtask

   task automatic pulseStart(input int g);
      start[g] = 1'b1;
      tick(1);
      start[g] = 1'b0;
   endtask

   task automatic waitDone(input int g, input int target);
      for (int i = 0; i < 200; i++) begin
         if (doneCnt[g] >= target) break;
         tick(1);
      end
      checkOutput("burst_done_seen", int'(doneCnt[g] >= target), 1);
   endtask

   task automatic checkResetOutputs(input int g);
      checkOutput("rst_rd_en", int'(rdEn[g]), 0);
      checkOutput("rst_m_valid", int'(mValid[g]), 0);
      checkOutput("rst_m_data", int'(mData[g]), 0);
      checkOutput("rst_m_last", int'(mLast[g]), 0);
      checkOutput("rst_busy", int'(busy[g]), 0);
      checkOutput("rst_burst_done", int'(burstDone[g]), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tick(3);
      for (int g = 0; g < NumDut; g++) checkResetOutputs(g);
      rst_n = 1'b1;
      tick(2);

      // Basic burst of four with an always-ready sink.
      mReady      = '1;
      checkLat[0] = 1;
      applyStimulus(0, 8'h11, 1'b0);
      applyStimulus(0, 8'h22, 1'b0);
      applyStimulus(0, 8'h33, 1'b0);
      applyStimulus(0, 8'h44, 1'b1);
      pulseStart(0);
      waitDone(0, 1);
      tick(2);

      // Backpressure: sink stalls for five cycles after the first valid word.
      checkLat[0] = 0;
      applyStimulus(0, 8'hA1, 1'b0);
      applyStimulus(0, 8'hB2, 1'b0);
      applyStimulus(0, 8'hC3, 1'b0);
      applyStimulus(0, 8'hD4, 1'b1);
      pulseStart(0);
      for (int i = 0; i < 20 && !mValid[0]; i++) tick(1);
      checkOutput("first_valid_seen", int'(mValid[0]), 1);
      mReady[0] = 1'b0;
      tick(5);
      mReady[0] = 1'b1;
      waitDone(0, 2);
      tick(2);

      // Empty stall: half the burst arrives ten cycles late.
      applyStimulus(0, 8'h01, 1'b0);
      applyStimulus(0, 8'h02, 1'b0);
      pulseStart(0);
      tick(10);
      applyStimulus(0, 8'h03, 1'b0);
      applyStimulus(0, 8'h04, 1'b1);
      waitDone(0, 3);
      tick(2);

      // Start held high across two bursts of three.
      checkLat[1] = 1;
      for (int i = 1; i <= 6; i++) applyStimulus(1, 8'(8'h60 + i), (i % 3) == 0);
      start[1] = 1'b1;
      waitDone(1, 1);
      start[1] = 1'b0;
      waitDone(1, 2);
      tick(2);

      // Reset after two reads: those words are lost, the next burst starts at 0x73.
      checkLat[0] = 1;
      fifoQ[0].push_back(8'h71);
      fifoQ[0].push_back(8'h72);
      applyStimulus(0, 8'h73, 1'b0);
      applyStimulus(0, 8'h74, 1'b0);
      applyStimulus(0, 8'h75, 1'b0);
      applyStimulus(0, 8'h76, 1'b1);
      pulseStart(0);
      for (int i = 0; i < 20 && rdInBurst[0] < 2; i++) tick(1);
      checkOutput("two_reads_before_reset", rdInBurst[0], 2);
      #2 rst_n = 1'b0;
      #1 checkResetOutputs(0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      pulseStart(0);
      waitDone(0, 4);
      tick(2);

      // burst_len of one: exactly one read with the extra word left in the FIFO.
      checkLat[2] = 1;
      applyStimulus(2, 8'h5A, 1'b1);
      fifoQ[2].push_back(8'h5B);
      pulseStart(2);
      waitDone(2, 1);
      tick(3);

      for (int g = 0; g < NumDut; g++) begin
         checkOutput("scoreboard_drained", expQ[g].size(), 0);
         checkOutput("fifo_words_left", fifoQ[g].size(), (g == 2) ? 1 : 0);
      end
      checkOutput("bursts_dut0", doneCnt[0], 4);
      checkOutput("bursts_dut1", doneCnt[1], 2);
      checkOutput("bursts_dut2", doneCnt[2], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the team's FIFOs. It runs on the FIFO read clock and pulls fixed-length bursts through the FIFO read port (`rd_en`/`fifo_empty`/`rd_data`, with data registered one cycle after `rd_en`). It presents the words on a valid/ready stream with a last-word marker. It is the consumer for `async_fifo`-style read ports and feeds downstream packet logic at one word per cycle.

## Interface
Parameters:
- `data_width`, 8, word width; must match the FIFO.
- `burst_len`, 16, words per burst; legal range 1 to 2^`len_width`-1.
- `len_width`, 5, width of the burst counters.

Ports:
- `rd_clk`, input, 1, the only clock (FIFO read clock).
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, request one burst; sampled only in IDLE.
- `fifo_empty`, input, 1, FIFO empty flag.
- `rd_en`, output, 1, FIFO read strobe (combinational).
- `rd_data`, input, `data_width`, FIFO read data; valid the cycle after `rd_en`. Zero otherwise.
- `m_data`, output, `data_width`, stream data.
- `m_valid`, output, 1, stream valid.
- `m_last`, output, 1, marks word `burst_len` of the burst; qualified by `m_valid`.
- `m_ready`, input, 1, stream ready.
- `busy`, output, 1, high in RUN and DRAIN.
- `burst_done`, output, 1, one-cycle pulse when the last word is accepted.

## Operation
- **States.**
  - IDLE: `start`=1 → RUN; clear `issued` and `sent`.
  - RUN: issue reads. When `issued` reaches `burst_len` on an issuing edge → DRAIN.
  - DRAIN: no reads. When the word with `m_last` is accepted → IDLE, and `burst_done`=1 for the next cycle.
  - Special case `burst_len`=1: RUN → DRAIN after a single read.
- **Read issue.** `rd_en` = RUN & ~`fifo_empty` & (`issued` < `burst_len`) & (`occ` + `inflight` − `pop` < 2).
  - `occ`: output buffer occupancy, 0 to 2.
  - `inflight`: registered copy of `rd_en`.
  - `pop`: `m_valid` & `m_ready`.
- **Capture.** When `inflight`=1, `rd_data` is written into the 2-entry output buffer. `rd_data` is never sampled otherwise (the FIFO drives zero when idle).
- **Output buffer.** 2-entry FIFO-ordered buffer. A push and a pop in the same cycle leave `occ` unchanged. `m_valid` = (`occ` ≠ 0). `m_data`/`m_last` come from the head entry.
- **m_last tagging.** The captured word is tagged last when it is the `burst_len`-th capture. Track this with a capture counter compared against `burst_len`.
- **Stream rule.** While `m_valid`=1 and `m_ready`=0, `m_data`, `m_last` and `m_valid` hold stable.
- **Start handling.** `start` is ignored outside IDLE. Deasserting `start` mid-burst does not abort the burst.
- **FIFO empty.** `fifo_empty` mid-burst stalls issue only. The burst resumes when data arrives; there is no timeout.
- **Counter widths.** All counters are `len_width` bits and saturate at `burst_len`; they never wrap.
- **Reset.** Asserting reset mid-burst returns to IDLE immediately and discards buffered data. Words already read from the FIFO are lost; this is intended.

## Timing
- Reset values: `rd_en` 0, `m_valid` 0, `m_data` 0, `m_last` 0, `busy` 0, `burst_done` 0; state IDLE; all counters 0.
- `start` sampled at edge E0 → `busy`=1 from E0. The first `rd_en` can rise in the cycle after E0.
- Latency: `rd_en` in cycle t → word captured at the end of t+1 → `m_valid` in cycle t+2.
- With `m_ready` held high and the FIFO non-empty, the block sustains 1 word per cycle.
- Burst duration with an always-ready sink and non-empty FIFO: `m_last` accepted at E0 + `burst_len` + 2 cycles. `burst_done` is high the cycle after that, and `busy` falls with the same edge.
- A new `start` may be accepted in the cycle `busy`=0.

## Structure
- Shared package `fifo_pkg`:
  - state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - buffer depth constant 2.
- One sub-module, `stream_buf2`: a 2-entry buffer with push/pop, `{last,data}` storage and `occ` output. The FSM, counters and `rd_en` logic stay in the top level.

## Test plan
- **Basic burst.** `burst_len`=4, FIFO preloaded with 0x11–0x44, `m_ready`=1, pulse `start`.
  - Exactly 4 `rd_en` cycles back-to-back.
  - `m_data` 0x11, 0x22, 0x33, 0x44 on consecutive cycles; `m_last` only on 0x44.
  - `burst_done` pulse one cycle later.
- **Backpressure.** `m_ready`=0 for 5 cycles after the first `m_valid`.
  - `rd_en` stops once `occ` + `inflight` reaches 2.
  - No word is lost or duplicated; the `m_data` sequence is unchanged.
- **Empty stall.** The FIFO holds 2 of 4 words; 2 more are written 10 cycles later.
  - `rd_en` stays 0 while `fifo_empty`=1.
  - The burst completes with correct order and `m_last` on word 4.
- **Start handling.** `start` held high continuously, 2 bursts of 3.
  - Exactly 3 reads per burst.
  - Second burst starts only after `busy`=0; no read occurs in the IDLE cycle.
- **Reset mid-burst.** Assert `rst_n`=0 after 2 words issued.
  - All outputs drop to reset values asynchronously.
  - A subsequent `start` reads from the current FIFO head.
- **burst_len=1.** Single read, `m_valid` with `m_last`=1, then `burst_done`.
